// File: rtl/led_count_gen.sv
// led_count_gen: 8-bit LED pattern source. Two raw buttons are synchronised
// and debounced; accepted presses start/pause the count or flip its
// direction. While running, leds steps by one every DIV clock cycles.
module led_count_gen #(
    parameter int DIV        = 12_000_000,
    parameter int DEB_CYCLES = 240_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_dir,
    output logic [7:0] leds,
    output logic       running,
    output logic       dir_up,
    output logic       tick
);

    localparam int PW = $clog2(DIV);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [PW-1:0] PC_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DC_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic {S_PAUSE, S_RUN} state_t;

    // index 0 = run button, index 1 = direction button
    logic [1:0]         btn_raw;
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         deb;
    logic [1:0]         deb_q;
    logic [1:0][DW-1:0] dc;
    logic [1:0]         press;
    logic               run_evt;
    logic               dir_evt;

    state_t             state_q;
    state_t             state_d;
    logic [PW-1:0]      pc;

    assign btn_raw = {btn_dir, btn_run};
    assign press   = deb & ~deb_q;
    assign run_evt = press[0];
    assign dir_evt = press[1];
    assign running = (state_q == S_RUN);

    // Two-flop synchronisers for the asynchronous button inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb   <= '0;
            deb_q <= '0;
            dc    <= '0;
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    dc[i] <= '0;
                end else if (dc[i] == DC_LAST) begin
                    deb[i] <= sync2[i];
                    dc[i]  <= '0;
                end else begin
                    dc[i] <= dc[i] + DW'(1);
                end
            end
        end
    end

    // Run/pause state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_PAUSE;
        else     state_q <= state_d;
    end

    // Each accepted run press toggles between PAUSE and RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PAUSE: if (run_evt) state_d = S_RUN;
            S_RUN:   if (run_evt) state_d = S_PAUSE;
            default: state_d = S_PAUSE;
        endcase
    end

    // Prescaler and LED stepping; a run event always restarts the prescaler,
    // so partial progress is discarded on pause and resume waits a full DIV
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= '0;
            tick <= 1'b0;
            leds <= 8'h55;
        end else begin
            tick <= 1'b0;
            if (state_q == S_RUN) begin
                if (pc == PC_LAST) begin
                    pc   <= '0;
                    tick <= 1'b1;
                    leds <= dir_up ? leds + 8'd1 : leds - 8'd1;
                end else begin
                    pc <= pc + PW'(1);
                end
            end
            if (run_evt) pc <= '0;
        end
    end

    // Direction toggles on each accepted press, in either state; a step on
    // the same edge still sees the old direction
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          dir_up <= 1'b1;
        else if (dir_evt) dir_up <= ~dir_up;
    end

endmodule
